// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller and the stage
// registers it drives.
package pipe_ctrl_pkg;

    localparam int REGNOBITS = 4;

    // A writer leaving D is visible to readers three cycles later, so two
    // cycles of pending state cover its time in A and M.
    localparam logic [1:0] SB_SET = 2'd2;

    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_STALL,
        CTRL_FLUSH
    } ctrl_e;

    // Field values a stage register loads when a nop is inserted.
    typedef struct packed {
        logic isnop;
        logic wrreg;
        logic wrmem;
    } nop_fields_t;

    localparam nop_fields_t NOP_FIELDS = '{isnop: 1'b1, wrreg: 1'b0, wrmem: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// D-stage operand information in, pipeline-register controls and debug state out.
interface pipe_hazard_ctrl_if #(
    parameter int REGNOBITS = 4,
    parameter int CNTBITS   = 16
);
    localparam int REGWORDS = 1 << REGNOBITS;

    logic                 valid_D;
    logic [REGNOBITS-1:0] rs_D;
    logic                 rsuse_D;
    logic [REGNOBITS-1:0] rt_D;
    logic                 rtuse_D;
    logic                 wrreg_D;
    logic [REGNOBITS-1:0] destreg_D;
    logic                 mispred_A;

    logic                 stall_F;
    logic                 stall_D;
    logic                 bubble_A;
    logic                 flush_D;
    logic [REGWORDS-1:0]  busy;
    logic [CNTBITS-1:0]   stallcnt;
    logic [CNTBITS-1:0]   flushcnt;

    modport master (
        output valid_D, rs_D, rsuse_D, rt_D, rtuse_D, wrreg_D, destreg_D, mispred_A,
        input  stall_F, stall_D, bubble_A, flush_D, busy, stallcnt, flushcnt
    );

    modport slave (
        input  valid_D, rs_D, rsuse_D, rt_D, rtuse_D, wrreg_D, destreg_D, mispred_A,
        output stall_F, stall_D, bubble_A, flush_D, busy, stallcnt, flushcnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sb_entry.sv
// One scoreboard slot: a 2-bit pending-write down-counter where a new set
// beats the decrement in the same cycle.
module sb_entry
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic set,
    output logic busy
);

    logic [1:0] cnt_reg;
    logic [1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (set) begin
            cnt_next = SB_SET;
        end else if (cnt_reg != 2'd0) begin
            cnt_next = cnt_reg - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= 2'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign busy = (cnt_reg != 2'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard stall and mispredict flush control for the F/D/A/M pipeline,
// with saturating debug counters of stall and flush events.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGNOBITS = pipe_ctrl_pkg::REGNOBITS,
    parameter int REGWORDS  = 1 << REGNOBITS,
    parameter int CNTBITS   = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    logic [REGWORDS-1:0] busy_raw;
    logic [REGWORDS-1:0] set_vec;
    logic                hazard;
    logic                issue;
    ctrl_e               ctrl;

    logic [CNTBITS-1:0]  stallcnt_reg;
    logic [CNTBITS-1:0]  stallcnt_next;
    logic [CNTBITS-1:0]  flushcnt_reg;
    logic [CNTBITS-1:0]  flushcnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < REGWORDS; gi++) begin : g_sb
            assign set_vec[gi] = issue && bus.wrreg_D &&
                                 (bus.destreg_D == REGNOBITS'(gi));

            sb_entry u_entry (
                .clk   (clk),
                .reset (reset),
                .set   (set_vec[gi]),
                .busy  (busy_raw[gi])
            );
        end
    endgenerate

    assign hazard = bus.valid_D &&
                    ((bus.rsuse_D && busy_raw[bus.rs_D]) ||
                     (bus.rtuse_D && busy_raw[bus.rt_D]));

    // Mispredict outranks hazard: the stalled D instruction is wrong-path anyway.
    always_comb begin
        ctrl = CTRL_RUN;
        if (!reset) begin
            if (bus.mispred_A) begin
                ctrl = CTRL_FLUSH;
            end else if (hazard) begin
                ctrl = CTRL_STALL;
            end
        end
    end

    assign issue        = !reset && bus.valid_D && (ctrl == CTRL_RUN);

    assign bus.stall_F  = (ctrl == CTRL_STALL);
    assign bus.stall_D  = (ctrl == CTRL_STALL);
    assign bus.bubble_A = (ctrl != CTRL_RUN);
    assign bus.flush_D  = (ctrl == CTRL_FLUSH);

    always_comb begin
        stallcnt_next = stallcnt_reg;
        flushcnt_next = flushcnt_reg;
        if (ctrl == CTRL_STALL && stallcnt_reg != '1) begin
            stallcnt_next = stallcnt_reg + CNTBITS'(1);
        end
        if (ctrl == CTRL_FLUSH && flushcnt_reg != '1) begin
            flushcnt_next = flushcnt_reg + CNTBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallcnt_reg <= '0;
            flushcnt_reg <= '0;
        end else begin
            stallcnt_reg <= stallcnt_next;
            flushcnt_reg <= flushcnt_next;
        end
    end

    // Debug outputs read as zero for the whole reset cycle, not just after it.
    assign bus.busy     = reset ? '0 : busy_raw;
    assign bus.stallcnt = reset ? '0 : stallcnt_reg;
    assign bus.flushcnt = reset ? '0 : flushcnt_reg;

endmodule
